// File: rtl/uart_frame_transmit.sv
// Multi-channel sample frame sender over one 8N1 UART line: sync byte, payload
// samples, XOR checksum. Frames are queued in a small FIFO with valid/ready.
module uart_frame_transmit #(
  parameter int         NUM_CHANNELS     = 4,
  parameter int         BYTES_PER_SAMPLE = 2,
  parameter int         FIFO_DEPTH       = 4,
  parameter logic [7:0] SYNC_BYTE        = 8'hA5,
  parameter bit         MSB_FIRST        = 1'b0,
  parameter int         BAUD_RATE        = 115200,
  parameter int         INPUT_CLOCK_FREQ = 100_000_000
) (
  input  logic                                            clk_in,
  input  logic                                            rst_n_in,
  input  logic [NUM_CHANNELS-1:0][BYTES_PER_SAMPLE*8-1:0] data_in,
  input  logic                                            valid_in,
  output logic                                            ready_out,
  output logic                                            busy_out,
  output logic                                            frame_done_out,
  output logic                                            dropped_out,
  output logic                                            tx_wire_out
);
  localparam int PAYLOAD_BYTES = NUM_CHANNELS * BYTES_PER_SAMPLE;
  localparam int PAYLOAD_W     = PAYLOAD_BYTES * 8;
  localparam int FRAME_BYTES   = 2 + PAYLOAD_BYTES;
  localparam int BAUD_PERIOD   = INPUT_CLOCK_FREQ / BAUD_RATE;
  localparam int BAUD_W        = (BAUD_PERIOD > 1) ? $clog2(BAUD_PERIOD) : 1;
  localparam int PTR_W         = $clog2(FIFO_DEPTH);
  localparam int CNT_W         = PTR_W + 1;
  localparam int IDX_W         = $clog2(FRAME_BYTES);

  localparam logic [BAUD_W-1:0] BAUD_LAST  = BAUD_W'(BAUD_PERIOD - 1);
  localparam logic [CNT_W-1:0]  FULL_COUNT = CNT_W'(FIFO_DEPTH);
  localparam logic [IDX_W-1:0]  LAST_IDX   = IDX_W'(FRAME_BYTES - 1);

  typedef enum logic [2:0] {IDLE, LOAD, START, DATA, STOP} state_t;

  state_t                 state;
  logic [PTR_W-1:0]       wr_ptr;
  logic [PTR_W-1:0]       rd_ptr;
  logic [CNT_W-1:0]       count;
  logic [CNT_W-1:0]       count_next;
  logic [IDX_W-1:0]       byte_idx;
  logic [2:0]             bit_idx;
  logic [BAUD_W-1:0]      baud_cnt;

  logic [PAYLOAD_W-1:0]   data_flat;
  logic [7:0]             csum_in;
  logic [PAYLOAD_W+7:0]   mem [FIFO_DEPTH];
  logic [PAYLOAD_W+7:0]   head_reg;
  logic [PAYLOAD_W-1:0]   payload_reg;
  logic [7:0]             csum_reg;
  logic [7:0]             frame_bytes [FRAME_BYTES];
  logic [7:0]             cur_byte;

  logic push;
  logic pop;
  logic baud_tick;
  logic last_byte;
  logic frame_end;
  logic idle_next;

  assign data_flat  = data_in;
  assign ready_out  = (count != FULL_COUNT);
  assign push       = valid_in && ready_out;
  assign pop        = (state == IDLE) && (count != '0);
  assign count_next = count + CNT_W'(push) - CNT_W'(pop);
  assign baud_tick  = (baud_cnt == BAUD_LAST);
  assign last_byte  = (byte_idx == LAST_IDX);
  assign frame_end  = (state == STOP) && baud_tick && last_byte;
  assign idle_next  = ((state == IDLE) && !pop) || frame_end;

  // The checksum is folded in at push time so a pop is a single registered read.
  always_comb begin
    csum_in = '0;
    for (int i = 0; i < PAYLOAD_BYTES; i++) begin
      csum_in = csum_in ^ data_flat[i*8 +: 8];
    end
  end

  always_ff @(posedge clk_in) begin
    if (push) begin
      mem[wr_ptr] <= {csum_in, data_flat};
    end
    if (pop) begin
      head_reg <= mem[rd_ptr];
    end
  end

  assign payload_reg = head_reg[PAYLOAD_W-1:0];
  assign csum_reg    = head_reg[PAYLOAD_W +: 8];

  assign frame_bytes[0]             = SYNC_BYTE;
  assign frame_bytes[FRAME_BYTES-1] = csum_reg;

  for (genvar gi = 0; gi < PAYLOAD_BYTES; gi++) begin : g_payload
    localparam int CH  = gi / BYTES_PER_SAMPLE;
    localparam int POS = gi % BYTES_PER_SAMPLE;
    localparam int SEL = MSB_FIRST ? (BYTES_PER_SAMPLE - 1 - POS) : POS;
    assign frame_bytes[gi+1] = payload_reg[(CH*BYTES_PER_SAMPLE + SEL)*8 +: 8];
  end

  assign cur_byte = frame_bytes[byte_idx];

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state          <= IDLE;
      wr_ptr         <= '0;
      rd_ptr         <= '0;
      count          <= '0;
      byte_idx       <= '0;
      bit_idx        <= '0;
      baud_cnt       <= '0;
      tx_wire_out    <= 1'b1;
      busy_out       <= 1'b0;
      frame_done_out <= 1'b0;
      dropped_out    <= 1'b0;
    end else begin
      count          <= count_next;
      dropped_out    <= valid_in && !ready_out;
      busy_out       <= (count_next != '0) || !idle_next;
      frame_done_out <= 1'b0;
      if (push) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end

      case (state)
        IDLE: begin
          tx_wire_out <= 1'b1;
          if (pop) begin
            byte_idx <= '0;
            state    <= LOAD;
          end
        end
        LOAD: begin
          baud_cnt    <= '0;
          tx_wire_out <= 1'b0;
          state       <= START;
        end
        START: begin
          if (baud_tick) begin
            baud_cnt    <= '0;
            bit_idx     <= '0;
            tx_wire_out <= cur_byte[0];
            state       <= DATA;
          end else begin
            baud_cnt <= baud_cnt + BAUD_W'(1);
          end
        end
        DATA: begin
          if (baud_tick) begin
            baud_cnt <= '0;
            if (bit_idx == 3'd7) begin
              tx_wire_out <= 1'b1;
              state       <= STOP;
            end else begin
              bit_idx     <= bit_idx + 3'd1;
              tx_wire_out <= cur_byte[bit_idx + 3'd1];
            end
          end else begin
            baud_cnt <= baud_cnt + BAUD_W'(1);
          end
        end
        STOP: begin
          if (baud_tick) begin
            baud_cnt <= '0;
            if (last_byte) begin
              frame_done_out <= 1'b1;
              state          <= IDLE;
            end else begin
              // Next byte's start bit follows the stop bit with no gap.
              byte_idx    <= byte_idx + IDX_W'(1);
              tx_wire_out <= 1'b0;
              state       <= START;
            end
          end else begin
            baud_cnt <= baud_cnt + BAUD_W'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
